// File: rtl/lcd_pkg.sv
// Shared types and command constants for the 16x2 LCD frame sequencer.
package lcd_pkg;

   localparam int unsigned ROW_W  = 128;
   localparam int unsigned N_COLS = 16;
   localparam int unsigned N_INIT = 4;

   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] ENTRY    = 8'h06;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] ROW0     = 8'h80;
   localparam logic [7:0] ROW1     = 8'hC0;

   typedef enum logic [2:0] {
      PWR, INIT, IDLE, ADDR_TOP, CHR_TOP, ADDR_BOT, CHR_BOT
   } state_e;

   typedef enum logic [1:0] {
      PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD
   } phase_e;

   // Column 0 lives in the most significant byte of a row.
   function automatic logic [7:0] col_char(input logic [ROW_W-1:0] row, input logic [3:0] col);
      logic [ROW_W-1:0] sh;
      sh = row << {col, 3'b000};
      return sh[ROW_W-1 -: 8];
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return FUNC_SET;
         2'd1:    return DISP_ON;
         2'd2:    return ENTRY;
         default: return CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: SETUP, enable PULSE, then HOLD (long hold after clear-display).
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int unsigned EN_CYCLES = 12,
   parameter int unsigned CMD_WAIT  = 600,
   parameter int unsigned CLR_WAIT  = 24000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   output logic       ready,
   output logic       lcd_rs,
   output logic       lcd_en,
   output logic [7:0] lcd_data
);

   localparam int unsigned MAX_WAIT = (CLR_WAIT > CMD_WAIT) ? CLR_WAIT : CMD_WAIT;
   localparam int unsigned MAX_CNT  = (MAX_WAIT > EN_CYCLES) ? MAX_WAIT : EN_CYCLES;
   localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);

   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             clr_q, clr_d;
   logic             en_q, en_d;
   logic             ready_q, ready_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         clr_q   <= 1'b0;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         clr_q   <= clr_d;
         en_q    <= en_d;
         ready_q <= ready_d;
      end
   end

   // A new byte may be accepted in the last HOLD cycle so writes run back to back.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      rs_d    = rs_q;
      data_d  = data_q;
      clr_d   = clr_q;
      case (phase_q)
         PH_IDLE, PH_HOLD: begin
            if (phase_q == PH_HOLD && cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (start) begin
               phase_d = PH_SETUP;
               rs_d    = rs;
               data_d  = data;
               clr_d   = !rs && (data == CLEAR);
            end else begin
               phase_d = PH_IDLE;
            end
         end
         PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = CNT_W'(EN_CYCLES - 1);
         end
         PH_PULSE: begin
            if (cnt_q == '0) begin
               phase_d = PH_HOLD;
               cnt_d   = clr_q ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: phase_d = PH_IDLE;
      endcase
      en_d    = (phase_d == PH_PULSE);
      ready_d = (phase_d == PH_IDLE) || (phase_d == PH_HOLD && cnt_d == '0);
   end

   assign ready    = ready_q;
   assign lcd_rs   = rs_q;
   assign lcd_en   = en_q;
   assign lcd_data = data_q;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Runs LCD power-on init, then streams snapshotted top/bottom rows as 34-byte frames on request.
module lcd_frame_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned EN_CYCLES = 12,
   parameter int unsigned CMD_WAIT  = 600,
   parameter int unsigned CLR_WAIT  = 24000,
   parameter int unsigned PWR_WAIT  = 240000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ROW_W-1:0] top,
   input  logic [ROW_W-1:0] bottom,
   input  logic             update_req,
   output logic             busy,
   output logic             done,
   output logic             init_done,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic             lcd_en,
   output logic [7:0]       lcd_data
);

   localparam int unsigned PWR_W = $clog2(PWR_WAIT + 1);

   state_e           state_q, state_d;
   logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [2:0]       init_idx_q, init_idx_d;
   logic [4:0]       col_q, col_d;
   logic [ROW_W-1:0] snap_top_q, snap_top_d;
   logic [ROW_W-1:0] snap_bot_q, snap_bot_d;
   logic             pending_q, pending_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             init_done_q, init_done_d;
   logic             wr_start_c, wr_rs_c, wr_ready;
   logic [7:0]       wr_byte_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PWR;
         pwr_cnt_q   <= '0;
         init_idx_q  <= '0;
         col_q       <= '0;
         snap_top_q  <= '0;
         snap_bot_q  <= '0;
         pending_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pwr_cnt_q   <= pwr_cnt_d;
         init_idx_q  <= init_idx_d;
         col_q       <= col_d;
         snap_top_q  <= snap_top_d;
         snap_bot_q  <= snap_bot_d;
         pending_q   <= pending_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         init_done_q <= init_done_d;
      end
   end

   // Bytes are issued whenever the writer is ready; the last byte of a frame is
   // retired (col == N_COLS) only once its HOLD completes.
   always_comb begin
      state_d     = state_q;
      pwr_cnt_d   = pwr_cnt_q;
      init_idx_d  = init_idx_q;
      col_d       = col_q;
      snap_top_d  = snap_top_q;
      snap_bot_d  = snap_bot_q;
      pending_d   = pending_q | (update_req && state_q != IDLE);
      busy_d      = busy_q;
      done_d      = 1'b0;
      init_done_d = init_done_q;
      wr_start_c  = 1'b0;
      wr_rs_c     = 1'b0;
      wr_byte_c   = '0;
      case (state_q)
         PWR: begin
            if (pwr_cnt_q == PWR_W'(PWR_WAIT - 1)) begin
               state_d    = INIT;
               init_idx_d = '0;
            end else begin
               pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
            end
         end
         INIT: begin
            if (wr_ready) begin
               if (init_idx_q == 3'(N_INIT)) begin
                  state_d     = IDLE;
                  init_done_d = 1'b1;
               end else begin
                  wr_start_c = 1'b1;
                  wr_byte_c  = init_cmd(init_idx_q[1:0]);
                  init_idx_d = init_idx_q + 3'd1;
               end
            end
         end
         IDLE: begin
            if (pending_q || update_req) begin
               snap_top_d = top;
               snap_bot_d = bottom;
               pending_d  = 1'b0;
               busy_d     = 1'b1;
               state_d    = ADDR_TOP;
            end
         end
         ADDR_TOP: begin
            if (wr_ready) begin
               wr_start_c = 1'b1;
               wr_byte_c  = ROW0;
               col_d      = '0;
               state_d    = CHR_TOP;
            end
         end
         CHR_TOP: begin
            if (wr_ready) begin
               wr_start_c = 1'b1;
               wr_rs_c    = 1'b1;
               wr_byte_c  = col_char(snap_top_q, col_q[3:0]);
               col_d      = col_q + 5'd1;
               if (col_q == 5'(N_COLS - 1)) state_d = ADDR_BOT;
            end
         end
         ADDR_BOT: begin
            if (wr_ready) begin
               wr_start_c = 1'b1;
               wr_byte_c  = ROW1;
               col_d      = '0;
               state_d    = CHR_BOT;
            end
         end
         CHR_BOT: begin
            if (wr_ready) begin
               if (col_q == 5'(N_COLS)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  wr_start_c = 1'b1;
                  wr_rs_c    = 1'b1;
                  wr_byte_c  = col_char(snap_bot_q, col_q[3:0]);
                  col_d      = col_q + 5'd1;
               end
            end
         end
         default: state_d = PWR;
      endcase
   end

   lcd_byte_writer #(
      .EN_CYCLES (EN_CYCLES),
      .CMD_WAIT  (CMD_WAIT),
      .CLR_WAIT  (CLR_WAIT)
   ) u_writer (
      .clk      (clk),
      .rst      (rst),
      .start    (wr_start_c),
      .rs       (wr_rs_c),
      .data     (wr_byte_c),
      .ready    (wr_ready),
      .lcd_rs   (lcd_rs),
      .lcd_en   (lcd_en),
      .lcd_data (lcd_data)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign init_done = init_done_q;
   assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected LCD bytes, a negedge monitor pops and checks them.
module tb_lcd_frame_sequencer;

   localparam int unsigned EN   = 2;
   localparam int unsigned CW   = 4;
   localparam int unsigned CLRW = 8;
   localparam int unsigned PW   = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         update_req = 1'b0;
   logic [127:0] top_r = '0;
   logic [127:0] bottom_r = '0;
   logic         busy, done, init_done, lcd_rs, lcd_rw, lcd_en;
   logic [7:0]   lcd_data;

   always #5 clk = ~clk;

   lcd_frame_sequencer #(
      .EN_CYCLES (EN),
      .CMD_WAIT  (CW),
      .CLR_WAIT  (CLRW),
      .PWR_WAIT  (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .top        (top_r),
      .bottom     (bottom_r),
      .update_req (update_req),
      .busy       (busy),
      .done       (done),
      .init_done  (init_done),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_data   (lcd_data)
   );

   typedef struct packed {
      logic       first;
      logic [8:0] val;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0, rise_cnt = 0, done_cnt = 0, done_cyc = 0;
   int   first_rise_cyc = 0, init_rise_cyc = 0, last_rise = 0, exp_gap = 7, en_len = 0;
   logic en_prev = 1'b0, initd_prev = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: each enable rise is one LCD byte.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         en_prev    = 1'b0;
         en_len     = 0;
         initd_prev = 1'b0;
      end else begin
         if (lcd_en && !en_prev) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", {lcd_rs, lcd_data}, 'h200);
            end else begin
               mon_e = exp_q.pop_front();
               chk("byte", {lcd_rs, lcd_data}, mon_e.val);
               if (mon_e.first) first_rise_cyc = cyc;
               else chk("spacing", cyc - last_rise, exp_gap);
               exp_gap = (mon_e.val == 9'h001) ? 11 : 7;
            end
            last_rise = cyc;
            en_len    = 1;
         end else if (lcd_en) begin
            en_len++;
         end else if (en_prev) begin
            chk("en_width", en_len, EN);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (init_done && !initd_prev) init_rise_cyc = cyc;
         en_prev    = lcd_en;
         initd_prev = init_done;
      end
   end

   function automatic logic [127:0] rand_row();
      logic [127:0] r;
      for (int c = 0; c < 16; c++)
         r[127-8*c -: 8] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      return r;
   endfunction

   task automatic push_init();
      exp_q.push_back('{first: 1'b1, val: 9'h038});
      exp_q.push_back('{first: 1'b0, val: 9'h00C});
      exp_q.push_back('{first: 1'b0, val: 9'h006});
      exp_q.push_back('{first: 1'b0, val: 9'h001});
   endtask

   task automatic push_frame(input logic [127:0] t, input logic [127:0] b);
      exp_q.push_back('{first: 1'b1, val: 9'h080});
      for (int c = 0; c < 16; c++) exp_q.push_back('{first: 1'b0, val: {1'b1, t[127-8*c -: 8]}});
      exp_q.push_back('{first: 1'b0, val: 9'h0C0});
      for (int c = 0; c < 16; c++) exp_q.push_back('{first: 1'b0, val: {1'b1, b[127-8*c -: 8]}});
   endtask

   task automatic pulse_req();
      update_req = 1'b1;
      @(negedge clk);
      update_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      update_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_en", lcd_en, 0);
      chk("rst_data", {lcd_rs, lcd_rw, lcd_data}, 0);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic check_quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("pwr_en_low", lcd_en, 0);
      end
   endtask

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("init_timeout", init_done, 1);
   endtask

   task automatic wait_dones(input int target);
      int n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", done_cnt, target);
   endtask

   task automatic wait_rises(input int target);
      int n = 0;
      while (rise_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rise_timeout", rise_cnt >= target, 1);
   endtask

   initial begin
      int base, r0, k, dn;
      logic [127:0] a_top, a_bot, b_top, b_bot;

      // Power-up and init sequence
      @(negedge clk);
      do_reset();
      push_init();
      check_quiet(PW);
      wait_init();
      chk("init_busy", busy, 0);
      chk("init_queue", exp_q.size(), 0);
      chk("rw_low", lcd_rw, 0);

      // Single frame, request while idle
      top_r    = "      Win       ";
      bottom_r = {16{8'h20}};
      push_frame(top_r, bottom_r);
      base = done_cnt;
      pulse_req();
      wait_dones(base + 1);
      chk("frame_len", done_cyc - first_rise_cyc, 34 * (1 + EN + CW) - 1);
      repeat (20) @(negedge clk);
      chk("done_once", done_cnt, base + 1);
      chk("idle_busy", busy, 0);
      chk("frame_queue", exp_q.size(), 0);

      // Coalesced requests during a frame, rows changed mid-frame
      for (int it = 0; it < 3; it++) begin
         a_top = rand_row();
         a_bot = rand_row();
         b_top = (it == 0) ? {16{8'h5F}} : rand_row();
         b_bot = rand_row();
         top_r    = a_top;
         bottom_r = a_bot;
         push_frame(a_top, a_bot);
         base = done_cnt;
         r0   = rise_cnt;
         pulse_req();
         k = int'($urandom_range(3, 15));
         wait_rises(r0 + k);
         chk("busy_mid_frame", busy, 1);
         for (int p = 0; p < 3; p++) begin
            pulse_req();
            repeat ($urandom_range(0, 4)) @(negedge clk);
         end
         top_r    = b_top;
         bottom_r = b_bot;
         push_frame(b_top, b_bot);
         wait_dones(base + 2);
         repeat (60) @(negedge clk);
         chk("coalesce_frames", done_cnt, base + 2);
         chk("coalesce_busy", busy, 0);
         chk("coalesce_queue", exp_q.size(), 0);
      end

      // Request during power-up wait is held until init completes
      do_reset();
      push_init();
      push_frame(top_r, bottom_r);
      base = done_cnt;
      @(negedge clk);
      chk("pwr_en_low", lcd_en, 0);
      update_req = 1'b1;
      @(negedge clk);
      update_req = 1'b0;
      chk("pwr_en_low", lcd_en, 0);
      check_quiet(PW - 2);
      wait_init();
      wait_dones(base + 1);
      chk("init_to_frame", first_rise_cyc - init_rise_cyc, 3);
      chk("early_req_queue", exp_q.size(), 0);

      // Reset in the middle of a bottom-row enable pulse
      top_r    = rand_row();
      bottom_r = rand_row();
      push_frame(top_r, bottom_r);
      base = done_cnt;
      r0   = rise_cnt;
      pulse_req();
      wait_rises(r0 + 26);
      chk("abort_en_high", lcd_en, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_en", lcd_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_init_done", init_done, 0);
      chk("abort_done", done, 0);
      exp_q.delete();
      dn = done_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_init();
      check_quiet(PW);
      wait_init();
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt, dn);
      chk("reinit_busy", busy, 0);
      chk("reinit_queue", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
